// File: rtl/gray_pos_tracker_pkg.sv
// Shared types for the gray-code position tracker: FSM state encoding and
// per-sample direction classification codes.
package gray_pos_tracker_pkg;

    typedef enum logic [1:0] {
        StUnlocked = 2'b00,
        StLocked   = 2'b01,
        StError    = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        DIR_HOLD = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DN   = 2'b10,
        DIR_BAD  = 2'b11
    } dir_e;

endpackage

// File: rtl/gray2bin.sv
// Combinational gray-to-binary decoder; MSB passes through, each lower bit
// is the XOR of the bit above it (binary) with its own gray bit.
module gray2bin #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] in_g,
    output logic [N-1:0] ou_b
);

    always_comb begin
        ou_b = '0;
        ou_b[N-1] = in_g[N-1];
        for (int i = int'(N) - 2; i >= 0; i--) begin
            ou_b[i] = ou_b[i+1] ^ in_g[i];
        end
    end

endmodule

// File: rtl/gray_pos_tracker.sv
// Tracks position from a sampled gray word: classifies each step against the
// previous sample, counts revolutions and latches an error on illegal jumps.
module gray_pos_tracker
    import gray_pos_tracker_pkg::*;
#(
    parameter int unsigned N = 3,
    parameter int unsigned W = 4
) (
    input  logic         in_clk,
    input  logic         rst,
    input  logic [N-1:0] in_g,
    input  logic         in_en,
    input  logic         in_clr_err,
    output logic [N-1:0] ou_b,
    output logic [1:0]   ou_dir,
    output logic [W-1:0] ou_wrap,
    output logic         ou_err,
    output logic         ou_lock
);

    state_e       state_q, state_d;
    logic [N-1:0] b_q, b_d;
    dir_e         dir_q, dir_d;
    logic [W-1:0] wrap_q, wrap_d;
    logic         err_q, err_d;
    logic         lock_q, lock_d;

    logic [N-1:0] bin_new;
    logic [N-1:0] diff;

    gray2bin #(
        .N (N)
    ) u_gray2bin (
        .in_g (in_g),
        .ou_b (bin_new)
    );

    // b_q doubles as the previous-sample register: both update together.
    assign diff = bin_new - b_q;

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        dir_d   = DIR_HOLD;
        wrap_d  = wrap_q;
        err_d   = err_q;

        unique case (state_q)
            StUnlocked: begin
                if (in_en) begin
                    b_d     = bin_new;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (in_en) begin
                    if (diff == '0) begin
                        dir_d = DIR_HOLD;
                    end else if (diff == N'(1)) begin
                        dir_d = DIR_UP;
                        b_d   = bin_new;
                        if (b_q == '1 && bin_new == '0) begin
                            wrap_d = wrap_q + W'(1);
                        end
                    end else if (diff == '1) begin
                        dir_d = DIR_DN;
                        b_d   = bin_new;
                        if (b_q == '0 && bin_new == '1) begin
                            wrap_d = wrap_q - W'(1);
                        end
                    end else begin
                        dir_d   = DIR_BAD;
                        err_d   = 1'b1;
                        state_d = StError;
                    end
                end
            end
            StError: begin
                if (in_clr_err) begin
                    err_d   = 1'b0;
                    state_d = StUnlocked;
                end
            end
            default: begin
                state_d = StUnlocked;
            end
        endcase

        lock_d = (state_d == StLocked);
    end

    always_ff @(posedge in_clk) begin
        if (rst) begin
            state_q <= StUnlocked;
            b_q     <= '0;
            dir_q   <= DIR_HOLD;
            wrap_q  <= '0;
            err_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            lock_q  <= lock_d;
        end
    end

    assign ou_b    = b_q;
    assign ou_dir  = dir_q;
    assign ou_wrap = wrap_q;
    assign ou_err  = err_q;
    assign ou_lock = lock_q;

endmodule

// File: tb/tb_gray_pos_tracker.sv
// Directed bench for gray_pos_tracker (N=3, W=4) with hand-computed expectations.
module tb_gray_pos_tracker;

    localparam int unsigned N = 3;
    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] g = '0;
    logic         en = 1'b0;
    logic         clr = 1'b0;
    logic [N-1:0] b;
    logic [1:0]   dir;
    logic [W-1:0] wrap;
    logic         err;
    logic         lock;

    int n_checks = 0;
    int n_errors = 0;

    gray_pos_tracker #(
        .N (N),
        .W (W)
    ) dut (
        .in_clk     (clk),
        .rst        (rst),
        .in_g       (g),
        .in_en      (en),
        .in_clr_err (clr),
        .ou_b       (b),
        .ou_dir     (dir),
        .ou_wrap    (wrap),
        .ou_err     (err),
        .ou_lock    (lock)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] gi, input logic eni, input logic clri,
                        input logic rsti);
        g   = gi;
        en  = eni;
        clr = clri;
        rst = rsti;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int eb, input int ed, input int ew,
                             input int ee, input int el);
        check_eq({tag, ".b"}, 32'(b), eb);
        check_eq({tag, ".dir"}, 32'(dir), ed);
        check_eq({tag, ".wrap"}, 32'(wrap), ew);
        check_eq({tag, ".err"}, 32'(err), ee);
        check_eq({tag, ".lock"}, 32'(lock), el);
    endtask

    // Gray codes indexed by binary value.
    logic [N-1:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                               3'b110, 3'b111, 3'b101, 3'b100};

    initial begin
        step(3'b000, 1'b0, 1'b0, 1'b1);
        check_all("reset", 0, 0, 0, 0, 0);

        // Forward sweep
        step(gtab[0], 1'b1, 1'b0, 1'b0);
        check_all("sweep0", 0, 0, 0, 0, 1);
        for (int i = 1; i < 8; i++) begin
            step(gtab[i], 1'b1, 1'b0, 1'b0);
            check_all($sformatf("sweep%0d", i), i, 1, 0, 0, 1);
        end

        // Up wrap 7 -> 0
        step(3'b000, 1'b1, 1'b0, 1'b0);
        check_all("upwrap", 0, 1, 1, 0, 1);

        // Down sweep across 0
        step(3'b001, 1'b1, 1'b0, 1'b0);
        check_all("dn_pre", 1, 1, 1, 0, 1);
        step(3'b000, 1'b1, 1'b0, 1'b0);
        check_all("dn_0", 0, 2, 1, 0, 1);
        step(3'b100, 1'b1, 1'b0, 1'b0);
        check_all("dn_7", 7, 2, 0, 0, 1);

        // Back up to b=1 (wrap again), then illegal jump to 6
        step(3'b000, 1'b1, 1'b0, 1'b0);
        check_all("re_up0", 0, 1, 1, 0, 1);
        step(3'b001, 1'b1, 1'b0, 1'b0);
        check_all("re_up1", 1, 1, 1, 0, 1);
        step(3'b101, 1'b1, 1'b0, 1'b0);
        check_all("illegal", 1, 3, 1, 1, 0);
        step(3'b110, 1'b1, 1'b0, 1'b0);
        check_all("err_ignore", 1, 0, 1, 1, 0);

        // Clear wins over simultaneous sample
        step(3'b011, 1'b1, 1'b1, 1'b0);
        check_all("clear", 1, 0, 1, 0, 0);
        step(3'b011, 1'b1, 1'b0, 1'b0);
        check_all("relock", 2, 0, 1, 0, 1);

        // Walk up to b=5
        step(3'b010, 1'b1, 1'b0, 1'b0);
        step(3'b110, 1'b1, 1'b0, 1'b0);
        step(3'b111, 1'b1, 1'b0, 1'b0);
        check_all("at5", 5, 1, 1, 0, 1);

        // Mid-run reset discards everything, even with a sample present
        step(3'b111, 1'b1, 1'b0, 1'b1);
        check_all("midreset", 0, 0, 0, 0, 0);
        step(3'b111, 1'b0, 1'b0, 1'b0);
        check_all("gate_unlk", 0, 0, 0, 0, 0);
        step(3'b111, 1'b1, 1'b0, 1'b0);
        check_all("lock5", 5, 0, 0, 0, 1);
        step(3'b111, 1'b1, 1'b0, 1'b0);
        check_all("hold5", 5, 0, 0, 0, 1);
        step(3'b010, 1'b0, 1'b0, 1'b0);
        check_all("gate_lk", 5, 0, 0, 0, 1);

        // Walk down 5 -> 0 -> 7: wrap goes 0 -> -1 (4'hF)
        for (int i = 4; i >= 0; i--) begin
            step(gtab[i], 1'b1, 1'b0, 1'b0);
            check_all($sformatf("down%0d", i), i, 2, 0, 0, 1);
        end
        step(gtab[7], 1'b1, 1'b0, 1'b0);
        check_all("dnwrap", 7, 2, 15, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gray_pos_tracker.md
Name: gray_pos_tracker

Overview:
Downstream consumer of the gray-code counter output. It samples an n-bit gray word, decodes it to binary and classifies each sample against the previous one as hold, step up, step down or illegal jump. It keeps a wrap-around (revolution) count and latches an error on any illegal jump. Status outputs feed the lab's display/LED logic.

Parameters:
N, 3, gray/binary word width; N >= 2
W, 4, wrap counter width (two's complement, modulo 2^W)

Ports:
in_clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_g  input  N  gray-code word from the upstream counter
in_en  input  1  sample strobe; in_g is processed only when high
in_clr_err  input  1  clears a latched error (ERROR -> UNLOCKED)
ou_b  output  N  registered binary decode of the last accepted sample
ou_dir  output  2  classification of the sample taken on the previous edge: 00 hold/none, 01 up, 10 down, 11 illegal
ou_wrap  output  W  signed revolution count
ou_err  output  1  sticky illegal-jump flag
ou_lock  output  1  high while in LOCKED

Behaviour:
- Reset (rst=1 at a rising edge): state=UNLOCKED; ou_b=0, ou_dir=00, ou_wrap=0, ou_err=0, ou_lock=0, previous-binary register=0. Reset overrides all other inputs. Reset mid-run discards all history.
- Decode: bin[N-1]=g[N-1]; bin[i]=bin[i+1]^g[i]. This path is combinational and feeds registers only.
- Latency: one cycle. A sample on edge k is reflected on ou_b/ou_dir/ou_wrap/ou_err after edge k.
- ou_dir is 00 on any edge without an accepted sample. It is a one-cycle pulse per sample.
- diff = (bin_new - bin_prev) mod 2^N.
- State UNLOCKED:
  - in_en=1: ou_b<=bin_new, prev<=bin_new, ou_dir<=00, go to LOCKED. No step classification on the first sample.
- State LOCKED (ou_lock=1):
  - in_en=1 and diff=0: ou_dir<=00.
  - in_en=1 and diff=1: ou_dir<=01. If bin_prev=2^N-1 and bin_new=0, ou_wrap<=ou_wrap+1.
  - in_en=1 and diff=2^N-1: ou_dir<=10. If bin_prev=0 and bin_new=2^N-1, ou_wrap<=ou_wrap-1.
  - in_en=1 and any other diff: ou_dir<=11, ou_err<=1, go to ERROR. ou_b and prev are NOT updated.
  - In every legal case, ou_b<=bin_new and prev<=bin_new.
  - in_clr_err is ignored in LOCKED.
- State ERROR (ou_lock=0, ou_err=1):
  - Samples are ignored and ou_dir=00. ou_b and ou_wrap hold.
  - in_clr_err=1: ou_err<=0, go to UNLOCKED. A sample arriving on the same edge is ignored (clear has priority).
- ou_wrap wraps modulo 2^W in both directions and never saturates.
- Multi-bit gray changes with |diff|=1 cannot occur; legality is defined purely by diff.
- The state register is the only FSM. Three states, binary encoded.

Decomposition:
- Shared package: state encoding (UNLOCKED, LOCKED, ERROR) and direction codes (DIR_HOLD=00, DIR_UP=01, DIR_DN=10, DIR_BAD=11).
- One sub-module, gray2bin: purely combinational, parameter N, in_g -> ou_b. The upstream counter's bench can reuse it.

Test Plan:
1. Reset then forward sweep (N=3, in_en=1 every cycle): in_g 000,001,011,010,110,111,101,100. Expect ou_lock=1 after the first sample; ou_b 0..7; ou_dir=01 from the second sample on; ou_err=0.
2. Up wrap: continue 100 -> 000. Expect ou_b=0, ou_dir=01, ou_wrap=1.
3. Down sweep across 0: 001,000,100. Expect ou_dir=10,10 with ou_b=0 then 7. ou_wrap decrements on 000->100, returning to 0 after the up-wrap of test 2.
4. Illegal jump: LOCKED at ou_b=1 (in_g=001), then in_g=101 (bin 6). Expect ou_dir=11 for one cycle, ou_err=1, ou_lock=0, ou_b stays 1. Further samples leave ou_b and ou_dir=00 unchanged.
5. Clear with simultaneous sample: in ERROR, drive in_clr_err=1 and in_en=1 with in_g=011. Expect ou_err=0, UNLOCKED, ou_b unchanged. The next sample 011 gives ou_b=2, ou_dir=00, ou_lock=1.
6. Mid-run reset, strobe gating and hold: with ou_wrap=1 and ou_b=5, assert rst for one edge. Expect all outputs 0 and UNLOCKED. With in_en=0, changing in_g must not change any output. A repeated identical sample gives ou_dir=00 with no state change.
